lsu_ctrl: RTL and testbench

Load/store initiator sitting between the CPU memory stage and the single-port word-wide data RAM. Accepts one byte/half/word access at a time from the pipeline and issues word-addressed RAM cycles. Sub-word stores are done as a read-modify-write sequence. Returns sign- or zero-extended load data and flags misaligned accesses without touching memory.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-type codes, FSM states and helpers for the load/store unit
//
// Purpose: constants and helpers imported by lsu_ctrl and lsu_align.
// Ports: none (package).
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 14;

  // Pipeline access-type encoding: bit 2 selects zero-extension for loads.
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_RD   = 2'd1;
  localparam lsu_state_t ST_WR   = 2'd2;
  localparam lsu_state_t ST_DONE = 2'd3;

  // Unknown type codes are rejected the same way as misaligned addresses.
  function automatic logic is_misaligned(input logic [2:0] rw_type, input logic [1:0] addr_lo);
    logic bad;
    case (rw_type)
      RW_B, RW_BU: bad = 1'b0;
      RW_H, RW_HU: bad = addr_lo[0];
      RW_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half lane extract+extend for loads and lane merge for stores
//
// Purpose: purely combinational data alignment driven by the latched address low bits and type.
// Ports:
//   i_addr_lo    byte offset within the word
//   i_type       access type code
//   i_word       word read from RAM
//   i_wdata      right-aligned store data
//   o_load_data  extended load result
//   o_merge_data RAM word with the store lane replaced
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_type,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    case (i_type)
      RW_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      RW_BU:   o_load_data = {24'd0, w_byte};
      RW_H:    o_load_data = {{16{w_half[15]}}, w_half};
      RW_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_word;
    endcase

    o_merge_data = i_word;
    case (i_type)
      RW_B, RW_BU: begin
        case (i_addr_lo)
          2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
          2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data[23:16] = i_wdata[7:0];
          default: o_merge_data[31:24] = i_wdata[7:0];
        endcase
      end
      RW_H, RW_HU: begin
        if (i_addr_lo[1]) o_merge_data[31:16] = i_wdata[15:0];
        else              o_merge_data[15:0]  = i_wdata[15:0];
      end
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store initiator between the pipeline memory stage and a word-wide RAM
//
// Purpose: one access at a time; sub-word stores via read-modify-write; misaligned/invalid
// accesses are answered without any RAM cycle.
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_req_*/o_req_ready         pipeline request handshake and payload
//   o_resp_*                    completion pulse, load data, misalign flag
//   o_ram_addr/we/din, i_ram_dout  single-port RAM, read data one cycle after address
module lsu_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_type,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_misalign,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [31:0]       o_ram_din,
  input  logic [31:0]       i_ram_dout
);

  lsu_state_t        r_state;
  logic              r_we;
  logic [2:0]        r_type;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_misalign;
  logic [31:0]       r_ram_din;

  logic              w_accept;
  logic              w_err;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;
  logic              w_unused_addr_hi;

  assign w_accept = i_req_valid && (r_state == ST_IDLE);
  assign w_err    = is_misaligned(i_req_type, i_req_addr[1:0]);

  // Byte-address bits above the RAM window are intentionally ignored.
  assign w_unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

  lsu_align u_align (
    .i_addr_lo   (r_addr[1:0]),
    .i_type      (r_type),
    .i_word      (i_ram_dout),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merge_data(w_merge_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_type     <= RW_B;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_misalign <= 1'b0;
      r_ram_din  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= i_req_we;
            r_type  <= i_req_type;
            r_addr  <= i_req_addr[ADDR_W+1:0];
            r_wdata <= i_req_wdata;
            if (w_err) begin
              // Response fields update only on entry to DONE so they hold between responses.
              r_rdata    <= 32'd0;
              r_misalign <= 1'b1;
              r_state    <= ST_DONE;
            end else if (i_req_we && (i_req_type == RW_W)) begin
              r_ram_din <= i_req_wdata;
              r_state   <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_we) begin
            r_ram_din <= w_merge_data;
            r_state   <= ST_WR;
          end else begin
            r_rdata    <= w_load_data;
            r_misalign <= 1'b0;
            r_state    <= ST_DONE;
          end
        end
        ST_WR: begin
          r_rdata    <= 32'd0;
          r_misalign <= 1'b0;
          r_state    <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the state register so reset removes the write strobe without waiting for a clock.
  assign o_req_ready     = (r_state == ST_IDLE);
  assign o_resp_valid    = (r_state == ST_DONE);
  assign o_ram_we        = (r_state == ST_WR);
  assign o_ram_addr      = (r_state == ST_IDLE) ? i_req_addr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];
  assign o_ram_din       = r_ram_din;
  assign o_resp_rdata    = r_rdata;
  assign o_resp_misalign = r_misalign;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a behavioural synchronous RAM
module tb_lsu_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_type = 3'b000;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misalign;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = 32'd0;

  logic [31:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] rdata; logic mis; int at; } resp_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] din; int at; } wr_exp_t;
  resp_exp_t rq[$];
  wr_exp_t   wq[$];

  lsu_ctrl #(.ADDR_W(AW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_type     (req_type),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_misalign(resp_misalign),
    .o_ram_addr     (ram_addr),
    .o_ram_we       (ram_we),
    .o_ram_din      (ram_din),
    .i_ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (rq.size() == 0) begin
        check_val("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_exp_t e;
        e = rq.pop_front();
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("resp_misalign", {31'd0, resp_misalign}, {31'd0, e.mis});
        check_val("resp_cycle", cyc, e.at);
      end
    end
    if (ram_we) begin
      if (wq.size() == 0) begin
        check_val("unexpected_ram_we", 32'd1, 32'd0);
      end else begin
        wr_exp_t w;
        w = wq.pop_front();
        check_val("ram_addr", {18'd0, ram_addr}, {18'd0, w.addr});
        check_val("ram_din", ram_din, w.din);
        check_val("ram_we_cycle", cyc, w.at);
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
    req_we    = we;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
  endtask

  // wlat < 0 means no RAM write is expected for this request.
  task automatic send(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic em, input int lat,
                      input int wlat, input logic [31:0] wdin);
    int n;
    @(negedge clk);
    drive(we, t, a, wd);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("accept_timeout", 32'd0, 32'd1);
    rq.push_back('{rdata: er, mis: em, at: cyc + lat});
    if (wlat >= 0) wq.push_back('{addr: a[AW+1:2], din: wdin, at: cyc + wlat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    mem[4] = 32'h8070F0A5;

    #2;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'd0);
    check_val("rst_resp_misalign", {31'd0, resp_misalign}, 32'd0);
    check_val("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_val("rst_ram_din", ram_din, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Loads from 0x8070F0A5
    send(1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b001, 32'h10, 32'd0, 32'hFFFFF0A5, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b101, 32'h12, 32'd0, 32'h00008070, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF8070, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b000, 32'h11, 32'd0, 32'hFFFFFFF0, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b100, 32'h12, 32'd0, 32'h00000070, 1'b0, 2, -1, 32'd0); drain();
    send(1'b0, 3'b010, 32'h10, 32'd0, 32'h8070F0A5, 1'b0, 2, -1, 32'd0); drain();

    // Half store RMW, then read back
    send(1'b1, 3'b001, 32'h12, 32'h00001234, 32'd0, 1'b0, 3, 2, 32'h1234F0A5); drain();
    send(1'b0, 3'b010, 32'h10, 32'd0, 32'h1234F0A5, 1'b0, 2, -1, 32'd0); drain();

    // Word store, then read back
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'hDEADBEEF); drain();
    send(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, -1, 32'd0); drain();

    // Byte store uses only wdata[7:0]
    send(1'b1, 3'b000, 32'h12, 32'hFFFFFF55, 32'd0, 1'b0, 3, 2, 32'hDE55BEEF); drain();
    send(1'b0, 3'b010, 32'h10, 32'd0, 32'hDE55BEEF, 1'b0, 2, -1, 32'd0); drain();

    // Rejected accesses: no RAM write, response in cycle 1
    send(1'b0, 3'b010, 32'h11, 32'd0, 32'd0, 1'b1, 1, -1, 32'd0); drain();
    send(1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1, -1, 32'd0); drain();
    send(1'b0, 3'b101, 32'h11, 32'd0, 32'd0, 1'b1, 1, -1, 32'd0); drain();
    send(1'b1, 3'b010, 32'h12, 32'h11111111, 32'd0, 1'b1, 1, -1, 32'd0); drain();
    send(1'b1, 3'b111, 32'h10, 32'h22222222, 32'd0, 1'b1, 1, -1, 32'd0); drain();
    check_val("err_store_mem", mem[4], 32'hDE55BEEF);

    // Reset during RD of a byte store aborts it
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h11, 32'h000000AA);
    check_val("abort_accept_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_val("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("abort_resp_rdata", resp_rdata, 32'd0);
    check_val("abort_resp_misalign", {31'd0, resp_misalign}, 32'd0);
    check_val("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check_val("abort_ram_din", ram_din, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("abort_mem", mem[4], 32'hDE55BEEF);
    check_val("abort_ready_after", {31'd0, req_ready}, 32'd1);

    // Two loads with req_valid held high
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h10, 32'd0);
    check_val("b2b_ready0", {31'd0, req_ready}, 32'd1);
    acc = cyc;
    rq.push_back('{rdata: 32'hDE55BEEF, mis: 1'b0, at: acc + 2});
    @(negedge clk);
    drive(1'b0, 3'b100, 32'h13, 32'd0);
    check_val("b2b_ready1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_val("b2b_ready2", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_val("b2b_ready3", {31'd0, req_ready}, 32'd1);
    check_val("b2b_accept_cycle", cyc, acc + 3);
    rq.push_back('{rdata: 32'h000000DE, mis: 1'b0, at: cyc + 2});
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
    $fatal(1, "timeout");
  end

endmodule
